// File: rtl/serial_sub_pkg.sv
// Shared constants and state encoding for the bit-serial subtractor.
package serial_sub_pkg;

    localparam int unsigned DefaultWidth = 8;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } sub_state_e;

endpackage

// File: rtl/serial_sub_fs.sv
// One-bit full subtractor cell: D = A ^ B ^ BI, BO = (~A & B) | (~(A ^ B) & BI).
module serial_sub_fs (
    input  logic A,
    input  logic B,
    input  logic BI,
    output logic D,
    output logic BO
);

    logic axb;
    logic n_a;
    logic n_axb;
    logic t_ab;
    logic t_bi;

    xor u_xor_ab (axb, A, B);
    xor u_xor_d  (D, axb, BI);
    not u_not_a  (n_a, A);
    not u_not_x  (n_axb, axb);
    and u_and_ab (t_ab, n_a, B);
    and u_and_bi (t_bi, n_axb, BI);
    or  u_or_bo  (BO, t_ab, t_bi);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial unsigned subtractor D = A - B, one bit per clock LSB first,
// with valid/ready handshakes on the operand and result sides.
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int unsigned W = DefaultWidth
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         IN_VALID,
    output logic         IN_READY,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    output logic         OUT_VALID,
    input  logic         OUT_READY,
    output logic [W-1:0] D,
    output logic         BO
);

    // One extra bit so the counter can hold W after the last step without wrapping.
    localparam int unsigned CntW = $clog2(W) + 1;

    sub_state_e    state_q, state_d;
    logic [W-1:0]  ra_q, ra_d;
    logic [W-1:0]  rb_q, rb_d;
    logic [W-1:0]  res_q, res_d;
    logic          borrow_q, borrow_d;
    logic          bo_q, bo_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic fs_d;
    logic fs_bo;

    serial_sub_fs u_fs (
        .A  (ra_q[0]),
        .B  (rb_q[0]),
        .BI (borrow_q),
        .D  (fs_d),
        .BO (fs_bo)
    );

    always_comb begin
        state_d  = state_q;
        ra_d     = ra_q;
        rb_d     = rb_q;
        res_d    = res_q;
        borrow_d = borrow_q;
        bo_d     = bo_q;
        cnt_d    = cnt_q;

        unique case (state_q)
            StIdle: begin
                if (IN_VALID) begin
                    ra_d     = A;
                    rb_d     = B;
                    borrow_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = StRun;
                end
            end
            StRun: begin
                res_d        = res_q >> 1;
                res_d[W-1]   = fs_d;
                borrow_d     = fs_bo;
                ra_d         = ra_q >> 1;
                rb_d         = rb_q >> 1;
                cnt_d        = cnt_q + CntW'(1);
                if (cnt_q == CntW'(W - 1)) begin
                    bo_d    = fs_bo;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (OUT_READY) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= StIdle;
            ra_q     <= '0;
            rb_q     <= '0;
            res_q    <= '0;
            borrow_q <= 1'b0;
            bo_q     <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            ra_q     <= ra_d;
            rb_q     <= rb_d;
            res_q    <= res_d;
            borrow_q <= borrow_d;
            bo_q     <= bo_d;
            cnt_q    <= cnt_d;
        end
    end

    // Handshake outputs come straight from the state register.
    assign IN_READY  = (state_q == StIdle);
    assign OUT_VALID = (state_q == StDone);
    assign D         = res_q;
    assign BO        = bo_q;

endmodule
